out_uart: RTL and testbench

OUT_UART -- requirements
Module: out_uart

---
 rtl/out_uart_pkg.sv | 7 +
 rtl/out_fifo.sv | 42 ++++
 rtl/out_uart.sv | 90 +++++++++
 tb/tb_out_uart.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/out_uart_pkg.sv
// out_uart_pkg: shared types and frame constants for the UART output block.
package out_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    typedef logic [DATA_BITS-1:0] byte_t;
endpackage

// File: rtl/out_fifo.sv
// out_fifo: first-word-fall-through byte buffer with occupancy count.
module out_fifo
    import out_uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  byte_t                      din,
    output byte_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    byte_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full buffer can still accept.
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/out_uart.sv
// out_uart: buffered 8N1 UART transmitter fed by CPU write strobes.
module out_uart
    import out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [7:0]                      i_data,
    input  logic                            i_wrOut,
    output logic                            o_tx,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_busy,
    output logic                            o_overflow
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    tx_state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [IW-1:0] idx, idx_n;
    byte_t shift, shift_n, head;
    logic pop, push, bit_end, tx_n;
    assign bit_end = timer == TW'(CLKS_PER_BIT - 1);
    assign push    = i_wrOut && (!o_full || pop);
    assign o_busy  = state != IDLE || !o_empty;
    out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (i_clk),
        .rst  (i_reset),
        .push (push),
        .pop  (pop),
        .din  (i_data),
        .head (head),
        .full (o_full),
        .empty(o_empty),
        .count(o_count)
    );
    always_comb begin
        state_n = state;
        timer_n = bit_end ? '0 : timer + TW'(1);
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (!o_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = START;
                end
            end
            START: if (bit_end) begin
                idx_n   = '0;
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                idx_n   = idx + IW'(1);
                state_n = idx == IW'(DATA_BITS - 1) ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                pop     = !o_empty;
                shift_n = o_empty ? shift : head;
                state_n = o_empty ? IDLE : START;
            end
        endcase
        // Line value is registered from the next state so o_tx has no input path.
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            shift      <= '0;
            o_tx       <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            shift      <= shift_n;
            o_tx       <= tx_n;
            o_overflow <= o_overflow || (i_wrOut && !push);
        end
    end
endmodule

// File: tb/tb_out_uart.sv
// tb_out_uart: randomized and directed checks of out_uart against a frame-level model.
module tb_out_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    logic       clk, reset, wr_out, tx, full, empty, busy, overflow;
    logic [7:0] data;
    logic [2:0] count;
    int checks = 0, errors = 0;
    logic [7:0] q[$];
    int         pos;
    logic [9:0] frame;
    logic       m_ovf;

    out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_data    (data),
        .i_wrOut   (wr_out),
        .o_tx      (tx),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .o_busy    (busy),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: pos counts cycles into the current 10-bit frame, -1 when idle.
    task automatic model(input logic wr, input logic [7:0] d, input logic rst);
        if (rst) begin
            q.delete();
            pos   = -1;
            m_ovf = 1'b0;
            return;
        end
        if (pos >= 0) begin
            pos++;
            if (pos == FRAME) pos = -1;
        end
        if (pos < 0 && q.size() > 0) begin
            frame = {1'b1, q.pop_front(), 1'b0};
            pos   = 0;
        end
        if (wr) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rst);
        @(negedge clk);
        wr_out = wr;
        data   = d;
        reset  = rst;
        @(posedge clk);
        model(wr, d, rst);
        #1;
        chk("tx", tx, pos < 0 ? 1'b1 : frame[pos / CPB]);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("busy", busy, pos >= 0 || q.size() > 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [9:0] line_a5;
        logic [7:0] burst[3];
        int guard;
        line_a5  = 10'b1101001010;
        burst    = '{8'h00, 8'hFF, 8'h3C};
        wr_out   = 1'b0;
        data     = 8'h00;
        reset    = 1'b1;
        pos      = -1;
        m_ovf    = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("reset_tx", tx, 1'b1);
        chk("reset_empty", empty, 1'b1);

        step(1'b1, 8'hA5, 1'b0);
        chk("a5_count_e0", count, 1);
        chk("a5_tx_e0", tx, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (k == 0) chk("a5_count_e1", count, 0);
            chk("a5_line", tx, line_a5[k / CPB]);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("a5_busy_end", busy, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, burst[i], 1'b0);
            chk("b3_count", count, i == 2 ? 2 : 1);
        end
        idle(3 * FRAME + 4);
        chk("b3_done", busy, 1'b0);

        for (int i = 1; i <= 6; i++) begin
            if (i == 6) chk("ovf_full", full, 1'b1);
            step(1'b1, 8'(i), 1'b0);
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, DEPTH);
        idle(5 * FRAME + 4);
        chk("ovf_sticky", overflow, 1'b1);

        step(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        guard = 0;
        while (pos != FRAME - 1 && guard < 200) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("pp_reach", guard < 200, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        chk("pp_count", count, DEPTH);
        chk("pp_noovf", overflow, 1'b0);
        idle(5 * FRAME + 4);

        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        guard = 0;
        while (pos != 4 * CPB + 1 && guard < 100) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        step(1'b0, 8'h00, 1'b1);
        chk("rst_tx", tx, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 1'b0);
        idle(2 * FRAME);

        for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 1'b1);
        chk("rstwr_count", count, 0);
        step(1'b1, 8'hC3, 1'b0);
        chk("rel_count_e0", count, 1);
        step(1'b0, 8'h00, 1'b0);
        chk("rel_tx_e1", tx, 1'b0);
        chk("rel_count_e1", count, 0);
        idle(FRAME);

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 99) < 8, 8'($urandom), $urandom_range(0, 999) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
